// File: rtl/am2910_pkg.sv
// Shared definitions for the am2910 microprogram sequencer: instruction codes
// and default geometry.
package am2910_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int DEPTH_DEF = 5;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } instr_e;

endpackage

// File: rtl/am2910_stack.sv
// Subroutine/loop LIFO. A push while full overwrites TOS and a pop while
// empty is ignored, so callers never have to guard either case.
module am2910_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic             full,
    output logic             empty
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   top;

    // With sp=0 the top index folds onto entry 0, whatever it last held.
    assign top   = (sp == '0) ? '0 : sp - SPW'(1);
    assign tos   = mem[top];
    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push) begin
            if (full) begin
                mem[top] <= din;
            end else begin
                mem[sp] <= din;
                sp      <= sp + SPW'(1);
            end
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/am2910.sv
// Am2910-style microprogram sequencer: next-address mux, instruction decode,
// microprogram counter and loop register around a small return stack.
module am2910
    import am2910_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [3:0]       instr,
    input  logic             ccen,
    input  logic             cc,
    input  logic             rld,
    input  logic             ci,
    output logic [WIDTH-1:0] y,
    output logic             full,
    output logic             pl_en,
    output logic             map_en,
    output logic             vect_en
);
    logic [WIDTH-1:0] upc, r, tos, y_nxt;
    logic             pass, r0;
    logic             push, pop, clr, r_ld, r_dec, map_sel, vect_sel;
    logic             stk_full, stk_empty;
    instr_e           op;

    assign op   = instr_e'(instr);
    assign pass = !ccen || cc;
    assign r0   = (r == '0);

    always_comb begin
        y_nxt    = upc;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        r_ld     = 1'b0;
        r_dec    = 1'b0;
        map_sel  = 1'b0;
        vect_sel = 1'b0;
        case (op)
            JZ:   begin y_nxt = '0; clr = 1'b1; end
            CJS:  if (pass) begin y_nxt = d; push = 1'b1; end
            JMAP: begin y_nxt = d; map_sel = 1'b1; end
            CJP:  if (pass) y_nxt = d;
            PUSH: begin push = 1'b1; r_ld = pass; end
            JSRP: begin push = 1'b1; y_nxt = pass ? d : r; end
            CJV:  begin vect_sel = 1'b1; if (pass) y_nxt = d; end
            JRP:  y_nxt = pass ? d : r;
            RFCT: if (!r0) begin y_nxt = tos; r_dec = 1'b1; end else pop = 1'b1;
            RPCT: if (!r0) begin y_nxt = d; r_dec = 1'b1; end
            CRTN: if (pass) begin y_nxt = tos; pop = 1'b1; end
            CJPP: if (pass) begin y_nxt = d; pop = 1'b1; end
            LDCT: r_ld = 1'b1;
            LOOP: if (pass) pop = 1'b1; else y_nxt = tos;
            CONT: ;
            TWB: begin
                if (pass) begin
                    pop   = 1'b1;
                    r_dec = !r0;
                end else if (!r0) begin
                    y_nxt = tos;
                    r_dec = 1'b1;
                end else begin
                    y_nxt = d;
                    pop   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset overrides the decode so the microcode store sees address 0.
    assign y       = reset ? '0 : y_nxt;
    assign map_en  = !reset && map_sel;
    assign vect_en = !reset && vect_sel;
    assign pl_en   = !(map_en || vect_en);
    assign full    = !reset && stk_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc <= '0;
            r   <= '0;
        end else begin
            upc <= y + WIDTH'(ci);
            if (rld || r_ld) r <= d;
            else if (r_dec)  r <= r - WIDTH'(1);
        end
    end

    am2910_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (upc),
        .tos   (tos),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule
